// File: rtl/imm_decode_queue_if.sv
// Handshake and immediate-generator bus for imm_decode_queue: fetch side, generator side, execute side.
interface imm_decode_queue_if #(
  parameter int unsigned width = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] in_instr;
  logic [width-1:0] in_pc;

  logic [width-1:0] gen_instr;
  logic [2:0]       gen_sel;
  logic [width-1:0] gen_imm;

  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_instr;
  logic [width-1:0] out_pc;
  logic [width-1:0] out_imm;
  logic [2:0]       out_sel;
  logic             out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, gen_imm, out_ready,
    output in_ready, gen_instr, gen_sel,
    output out_valid, out_instr, out_pc, out_imm, out_sel, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, gen_imm, out_ready,
    input  in_ready, gen_instr, gen_sel,
    input  out_valid, out_instr, out_pc, out_imm, out_sel, out_illegal
  );
endinterface

// File: rtl/imm_decode_queue.sv
// Decode front end: classifies opcodes into immediate formats, drives the immediate generator,
// and buffers {instr, pc, imm, sel, illegal} in a 2-entry queue toward execute.
module imm_decode_queue #(
  parameter int unsigned width = 32,
  parameter int unsigned cnt_w = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  imm_decode_queue_if.slave bus,
  output logic [cnt_w-1:0] illegal_count
);

  localparam logic [2:0] SEL_I    = 3'b000;
  localparam logic [2:0] SEL_S    = 3'b001;
  localparam logic [2:0] SEL_B    = 3'b010;
  localparam logic [2:0] SEL_U    = 3'b011;
  localparam logic [2:0] SEL_J    = 3'b100;
  localparam logic [2:0] SEL_NONE = 3'b111;

  typedef struct packed {
    logic [width-1:0] instr;
    logic [width-1:0] pc;
    logic [width-1:0] imm;
    logic [2:0]       sel;
    logic             illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic             head, tail, head_n, tail_n;
  logic             in_ready_q;
  logic             out_valid_q;
  entry_t           out_q;
  entry_t           mem [2];
  logic [cnt_w-1:0] count_q;

  logic   [2:0] sel_c;
  logic         illegal_c;
  logic         accept_c;
  logic         pop_c;
  entry_t       new_entry_c;
  entry_t       head_entry_c;

  // Opcode classification into the generator's immSel encoding
  always_comb begin
    sel_c     = SEL_NONE;
    illegal_c = 1'b0;
    case (bus.in_instr[6:0])
      7'b0000011, 7'b0001111, 7'b0010011,
      7'b1100111, 7'b1110011:             sel_c = SEL_I;
      7'b0100011:                         sel_c = SEL_S;
      7'b1100011:                         sel_c = SEL_B;
      7'b0110111, 7'b0010111:             sel_c = SEL_U;
      7'b1101111:                         sel_c = SEL_J;
      7'b0110011:                         sel_c = SEL_NONE;
      default:                            illegal_c = 1'b1;
    endcase
  end

  assign bus.gen_instr = bus.in_instr;
  assign bus.gen_sel   = sel_c;

  assign accept_c = bus.in_valid & in_ready_q & ~flush;
  assign pop_c    = out_valid_q & bus.out_ready & ~flush;

  always_comb begin
    new_entry_c.instr   = bus.in_instr;
    new_entry_c.pc      = bus.in_pc;
    new_entry_c.imm     = bus.gen_imm;
    new_entry_c.sel     = sel_c;
    new_entry_c.illegal = illegal_c;
  end

  // Occupancy state and pointer advance
  always_comb begin
    state_n = state;
    head_n  = head;
    tail_n  = tail;
    if (flush) begin
      state_n = EMPTY;
      head_n  = 1'b0;
      tail_n  = 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept_c) begin
            state_n = ONE;
            tail_n  = tail + 1'b1;
          end
        end
        ONE: begin
          if (accept_c && !pop_c) begin
            state_n = FULL;
            tail_n  = tail + 1'b1;
          end else if (!accept_c && pop_c) begin
            state_n = EMPTY;
            head_n  = head + 1'b1;
          end else if (accept_c && pop_c) begin
            head_n  = head + 1'b1;
            tail_n  = tail + 1'b1;
          end
        end
        FULL: begin
          if (pop_c) begin
            state_n = ONE;
            head_n  = head + 1'b1;
          end
        end
        default: begin
          state_n = EMPTY;
          head_n  = 1'b0;
          tail_n  = 1'b0;
        end
      endcase
    end
  end

  // The next head is the incoming word when it lands in the slot the head will point at
  always_comb begin
    if (accept_c && (head_n == tail)) head_entry_c = new_entry_c;
    else                              head_entry_c = mem[head_n];
  end

  always_ff @(posedge clk) begin
    if (accept_c) mem[tail] <= new_entry_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      head        <= 1'b0;
      tail        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      count_q     <= '0;
    end else begin
      state       <= state_n;
      head        <= head_n;
      tail        <= tail_n;
      in_ready_q  <= (state_n != FULL);
      out_valid_q <= (state_n != EMPTY);
      if (state_n != EMPTY) out_q <= head_entry_c;
      if (accept_c && illegal_c && (count_q != {cnt_w{1'b1}}))
        count_q <= count_q + cnt_w'(1);
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_instr   = out_q.instr;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_sel     = out_q.sel;
  assign bus.out_illegal = out_q.illegal;
  assign illegal_count   = count_q;

endmodule

// File: tb/tb_imm_decode_queue.sv
// Bench for imm_decode_queue: directed scenarios plus random traffic against a queue-based model.
module tb_imm_decode_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [3:0] illegal_count;

  imm_decode_queue_if #(.width(32)) bus ();

  imm_decode_queue #(.width(32), .cnt_w(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .bus           (bus),
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  sel;
    logic        ill;
  } ent_t;

  int          checks = 0;
  int          failures = 0;
  ent_t        q [$];
  int          cnt = 0;
  logic [31:0] log_imm [$];
  logic [31:0] log_instr [$];
  logic [2:0]  log_sel [$];
  logic        log_ill [$];

  logic [31:0] stream_w   [5] = '{32'h00500093, 32'h00112623, 32'hFE000EE3, 32'h123450B7, 32'h008000EF};
  logic [31:0] stream_imm [5] = '{32'h00000005, 32'h0000000C, 32'hFFFFFFFC, 32'h12345000, 32'h00000008};
  logic [2:0]  stream_sel [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
  logic [31:0] pool       [12] = '{32'h00500093, 32'h00112623, 32'hFE000EE3, 32'h123450B7,
                                   32'h008000EF, 32'h002081B3, 32'h0000007F, 32'hFFF10113,
                                   32'h00001017, 32'h0000000F, 32'h00008067, 32'h00000073};

  // Format of an opcode as the ISA defines it; {illegal, sel}
  function automatic logic [3:0] ref_fmt(input logic [31:0] instr);
    logic [6:0] op;
    op = instr[6:0];
    if (op == 7'h03 || op == 7'h0F || op == 7'h13 || op == 7'h67 || op == 7'h73) return 4'b0_000;
    if (op == 7'h23) return 4'b0_001;
    if (op == 7'h63) return 4'b0_010;
    if (op == 7'h37 || op == 7'h17) return 4'b0_011;
    if (op == 7'h6F) return 4'b0_100;
    if (op == 7'h33) return 4'b0_111;
    return 4'b1_111;
  endfunction

  // Reference immediate generator (RV32 immediate formats)
  function automatic logic [31:0] immgen(input logic [31:0] i, input logic [2:0] sel);
    case (sel)
      3'b000:  return {{20{i[31]}}, i[31:20]};
      3'b001:  return {{20{i[31]}}, i[31:25], i[11:7]};
      3'b010:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'b011:  return {i[31:12], 12'b0};
      3'b100:  return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  always_comb bus.gen_imm = immgen(bus.gen_instr, bus.gen_sel);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_state();
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
    chk("illegal_count", 64'(illegal_count), 64'(cnt));
    if (q.size() > 0) begin
      chk("out_instr", 64'(bus.out_instr), 64'(q[0].instr));
      chk("out_pc", 64'(bus.out_pc), 64'(q[0].pc));
      chk("out_imm", 64'(bus.out_imm), 64'(q[0].imm));
      chk("out_sel", 64'(bus.out_sel), 64'(q[0].sel));
      chk("out_illegal", 64'(bus.out_illegal), 64'(q[0].ill));
    end
  endtask

  // One cycle: check outputs, drive inputs, then advance the model on the clock edge
  task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    logic       acc, pp;
    logic [3:0] f;
    ent_t       e;
    @(negedge clk);
    compare_state();
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    f = ref_fmt(instr);
    chk("gen_instr", 64'(bus.gen_instr), 64'(instr));
    chk("gen_sel", 64'(bus.gen_sel), 64'(f[2:0]));
    acc = v && (q.size() < 2) && !fl;
    pp  = (q.size() > 0) && ordy && !fl;
    if (pp) begin
      log_imm.push_back(bus.out_imm);
      log_instr.push_back(bus.out_instr);
      log_sel.push_back(bus.out_sel);
      log_ill.push_back(bus.out_illegal);
    end
    e.instr = instr;
    e.pc    = pc;
    e.sel   = f[2:0];
    e.ill   = f[3];
    e.imm   = immgen(instr, f[2:0]);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (e.ill && cnt != 15) cnt++;
      end
    end
  endtask

  task automatic clear_logs();
    log_imm.delete();
    log_instr.delete();
    log_sel.delete();
    log_ill.delete();
  endtask

  initial begin
    logic [31:0] w;
    int          c0;
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_imm", 64'(bus.out_imm), 64'd0);
    chk("rst_count", 64'(illegal_count), 64'd0);
    reset = 1'b0;

    // Streaming with execute always ready
    clear_logs();
    for (int i = 0; i < 5; i++) step(1'b1, stream_w[i], 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
    repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("stream_n", 64'(log_imm.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < log_imm.size()) begin
        chk($sformatf("stream_imm%0d", i), 64'(log_imm[i]), 64'(stream_imm[i]));
        chk($sformatf("stream_sel%0d", i), 64'(log_sel[i]), 64'(stream_sel[i]));
      end
    end

    // Backpressure: third word waits for in_ready to return
    clear_logs();
    step(1'b1, 32'h00A00113, 32'h2000, 1'b0, 1'b0);
    step(1'b1, 32'h00B00193, 32'h2004, 1'b0, 1'b0);
    step(1'b1, 32'h00C00213, 32'h2008, 1'b0, 1'b0);
    chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    step(1'b1, 32'h00C00213, 32'h2008, 1'b1, 1'b0);
    step(1'b1, 32'h00C00213, 32'h2008, 1'b1, 1'b0);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bp_n", 64'(log_instr.size()), 64'd3);
    if (log_instr.size() == 3) begin
      chk("bp_order0", 64'(log_instr[0]), 64'h00A00113);
      chk("bp_order1", 64'(log_instr[1]), 64'h00B00193);
      chk("bp_order2", 64'(log_instr[2]), 64'h00C00213);
    end

    // Illegal opcodes followed by a register-register add
    clear_logs();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h0000007F, 32'h3000 + 32'(4 * i), 1'b1, 1'b0);
    step(1'b1, 32'h002081B3, 32'h300C, 1'b1, 1'b0);
    repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("ill_count3", 64'(illegal_count), 64'd3);
    chk("ill_n", 64'(log_ill.size()), 64'd4);
    if (log_ill.size() == 4) begin
      for (int i = 0; i < 3; i++) chk($sformatf("ill_flag%0d", i), 64'(log_ill[i]), 64'd1);
      chk("add_illegal", 64'(log_ill[3]), 64'd0);
      chk("add_sel", 64'(log_sel[3]), 64'd7);
      chk("add_imm", 64'(log_imm[3]), 64'd0);
    end

    // Flush with the queue full, an input offered and execute ready
    clear_logs();
    step(1'b1, 32'h00100293, 32'h4000, 1'b0, 1'b0);
    step(1'b1, 32'h00200313, 32'h4004, 1'b0, 1'b0);
    c0 = cnt;
    step(1'b1, 32'h0000007F, 32'h4008, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush_count", 64'(illegal_count), 64'(c0));
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("flush_no_output", 64'(log_instr.size()), 64'd0);

    // Counter saturation at 4 bits
    for (int i = 0; i < 16; i++) step(1'b1, 32'h0000007F, 32'h5000 + 32'(4 * i), 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("sat_count", 64'(illegal_count), 64'hF);
    step(1'b1, 32'h0000007F, 32'h5100, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("sat_hold", 64'(illegal_count), 64'hF);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(3, 0) == 0) w = $urandom;
      else w = pool[$urandom_range(11, 0)];
      step(1'($urandom_range(3, 0) != 0), w, $urandom, 1'($urandom_range(2, 0) != 0),
           1'($urandom_range(15, 0) == 0));
    end

    // Asynchronous reset between edges with two entries queued
    step(1'b1, 32'h00700393, 32'h6000, 1'b0, 1'b0);
    step(1'b1, 32'h00800413, 32'h6004, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_out_instr", 64'(bus.out_instr), 64'd0);
    chk("arst_out_pc", 64'(bus.out_pc), 64'd0);
    chk("arst_out_imm", 64'(bus.out_imm), 64'd0);
    chk("arst_out_sel", 64'(bus.out_sel), 64'd0);
    chk("arst_out_illegal", 64'(bus.out_illegal), 64'd0);
    chk("arst_count", 64'(illegal_count), 64'd0);
    q.delete();
    cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 32'h00500093, 32'h7000, 1'b1, 1'b0);
    repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
